oa_fifo: RTL and testbench

- Row-buffer and serializer between the systolic array output and oa_writer.
- Accepts full-width OA row vectors (VLEN x DATA_WIDTH) from the array and stores them in a row FIFO.
- Per tile, signals oa_fifo_req and samples vec_valid_num_col from oa_writer.
- Streams each row as 32-bit words with byte masks and switch_row on the last word of each row.

---
 rtl/oa_fifo.sv | 152 +++++++++++++++
 tb/tb_oa_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oa_fifo.sv
// oa_fifo: row FIFO between the systolic array and oa_writer.
// Stores full-width output rows, requests a tile transfer from oa_writer,
// then serializes each stored row into 32-bit words with byte masks.
module oa_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int VLEN       = 16,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VLEN*DATA_WIDTH-1:0]   in_data,
    input  logic                         in_last,
    output logic                         oa_fifo_req,
    input  logic [$clog2(VLEN)-1:0]      vec_valid_num_col,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [31:0]                  output_data,
    output logic [3:0]                   output_mask,
    output logic                         switch_row,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int RW  = VLEN * DATA_WIDTH;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int NCW = $clog2(VLEN) + 1;
    localparam int WW  = (VLEN / 4 > 1) ? $clog2(VLEN / 4) : 1;

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("oa_fifo: DATA_WIDTH must be 8");
    end
    if ((VLEN % 4) != 0 || VLEN < 4) begin : g_bad_vlen
        $error("oa_fifo: VLEN must be a multiple of 4 and at least 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("oa_fifo: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [RW:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rst_done;
    logic [NCW-1:0]  ncol;
    logic [NCW-1:0]  nwords;
    logic [WW-1:0]   w;
    logic            push, pop, hs, last_word;
    logic [RW-1:0]   head_data;
    logic            head_last;

    assign in_ready   = rst_done && (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    assign head_data  = mem[rd_ptr][RW-1:0];
    assign head_last  = mem[rd_ptr][RW];

    assign nwords     = (ncol + NCW'(3)) >> 2;
    assign last_word  = (NCW'(w) == (nwords - NCW'(1)));

    assign output_valid = (state == XFER) && (count != '0);
    assign switch_row   = output_valid && last_word;
    assign hs           = output_valid && output_ready;

    // in_ready stays low while reset is held and rises on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // Row storage write port; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_last, in_data};
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Tile FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Tile FSM next-state, request pulse and row pop
    always_comb begin
        state_n     = state;
        oa_fifo_req = 1'b0;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) state_n = REQ;
            end
            REQ: begin
                oa_fifo_req = 1'b1;
                state_n     = XFER;
            end
            XFER: begin
                if (hs && last_word) begin
                    pop = 1'b1;
                    if (head_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Column count is latched once per tile; word index advances per handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncol <= '0;
            w    <= '0;
        end else if (state == REQ) begin
            ncol <= (vec_valid_num_col == '0) ? NCW'(VLEN) : NCW'(vec_valid_num_col);
            w    <= '0;
        end else if (hs) begin
            w <= last_word ? '0 : w + WW'(1);
        end
    end

    // Word data and byte mask for the current word of the head row
    always_comb begin
        output_data = '0;
        output_mask = '0;
        if (state == XFER) begin
            output_data = head_data[32*w +: 32];
            for (int unsigned b = 0; b < 4; b++) begin
                output_mask[b] = ((32'(w) << 2) + b) < 32'(ncol);
            end
        end
    end

endmodule

// File: tb/tb_oa_fifo.sv
// Directed self-checking bench for oa_fifo.
module tb_oa_fifo;

    localparam int VLEN  = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [VLEN*DW-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              oa_fifo_req;
    logic [3:0]        vec_valid_num_col = '0;
    logic              output_valid;
    logic              output_ready = 1'b0;
    logic [31:0]       output_data;
    logic [3:0]        output_mask;
    logic              switch_row;
    logic [3:0]        fifo_count;

    oa_fifo #(.DATA_WIDTH(DW), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .oa_fifo_req(oa_fifo_req), .vec_valid_num_col(vec_valid_num_col),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .output_mask(output_mask),
        .switch_row(switch_row), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        s;
    } word_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          req_cnt = 0;
    word_t       got[$];
    logic        prev_stall = 1'b0;
    word_t       prev_w = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collect accepted words, count request pulses, check stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {output_valid, output_data, output_mask, switch_row}, {1'b1, prev_w});
            if (oa_fifo_req) req_cnt <= req_cnt + 1;
            if (output_valid && output_ready) got.push_back({output_data, output_mask, switch_row});
            prev_stall <= output_valid && !output_ready;
            prev_w     <= {output_data, output_mask, switch_row};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VLEN*DW-1:0] row(input logic [7:0] base);
        logic [VLEN*DW-1:0] r;
        for (int i = 0; i < VLEN; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [7:0] base, input logic last);
        logic ok;
        in_valid = 1'b1;
        in_data  = row(base);
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        if (!ok) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 2000 && got.size() < n; i++) step();
        step();
    endtask

    // Expected words for a tile: byte b of word w is element 4w+b, mask from ncol
    task automatic check_tile(input string tag, input logic [7:0] bases[$], input int ncol);
        int    nw;
        word_t e, a;
        nw = (ncol + 3) / 4;
        foreach (bases[r]) begin
            for (int w = 0; w < nw; w++) begin
                for (int b = 0; b < 4; b++) begin
                    e.d[8*b +: 8] = bases[r] + 8'(4*w + b);
                    e.m[b]        = (4*w + b) < ncol;
                end
                e.s = (w == nw - 1);
                if (got.size() == 0) begin
                    chk($sformatf("%s_missing_r%0dw%0d", tag, r, w), 0, 1);
                end else begin
                    a = got.pop_front();
                    chk($sformatf("%s_r%0dw%0d", tag, r, w), a, e);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int         r0;
        int         idx;
        logic       acc;

        // Reset values
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {oa_fifo_req, output_valid, output_data, output_mask, switch_row}, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", in_ready, 1);

        // Test 1: two full-width rows
        vec_valid_num_col = 4'd0;
        output_ready = 1'b1;
        push_row(8'h00, 1'b0);
        push_row(8'h40, 1'b1);
        wait_words(8);
        repeat (5) step();
        chk("t1_req_cnt", req_cnt, 1);
        chk("t1_count", fifo_count, 0);
        chk("t1_idle", {output_valid, oa_fifo_req}, 0);
        q.delete(); q.push_back(8'h00); q.push_back(8'h40);
        check_tile("t1", q, 16);
        chk("t1_leftover", got.size(), 0);

        // Test 2: ncol=6 single-row tile
        vec_valid_num_col = 4'd6;
        push_row(8'h80, 1'b1);
        wait_words(2);
        repeat (3) step();
        chk("t2_req_cnt", req_cnt, 2);
        q.delete(); q.push_back(8'h80);
        check_tile("t2", q, 6);
        chk("t2_leftover", got.size(), 0);

        // Test 3: fill with no drain, ninth row held until the first pop
        vec_valid_num_col = 4'd0;
        output_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            push_row(8'(16*i), 1'b0);
            q.push_back(8'(16*i));
        end
        chk("t3_full_count", fifo_count, 8);
        chk("t3_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = row(8'h90);
        in_last  = 1'b1;
        q.push_back(8'h90);
        repeat (3) step();
        chk("t3_held_count", fifo_count, 8);
        output_ready = 1'b1;
        repeat (4) step();
        chk("t3_after_pop_count", fifo_count, 7);
        chk("t3_after_pop_ready", in_ready, 1);
        step();
        chk("t3_ninth_accepted", fifo_count, 8);
        in_valid = 1'b0;
        wait_words(36);
        repeat (3) step();
        check_tile("t3", q, 16);
        chk("t3_leftover", got.size(), 0);

        // Test 4: random backpressure, 3 tiles of 4 rows, ncol=10
        vec_valid_num_col = 4'd10;
        r0 = req_cnt;
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h03 + 8'(20*i)));
        idx = 0;
        for (int cyc = 0; cyc < 3000 && got.size() < 36; cyc++) begin
            if (idx < 12) begin
                in_valid = 1'b1;
                in_data  = row(q[idx]);
                in_last  = (idx % 4) == 3;
            end else begin
                in_valid = 1'b0;
            end
            output_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        output_ready = 1'b1;
        repeat (4) step();
        chk("t4_req_cnt", req_cnt - r0, 3);
        check_tile("t4", q, 10);
        chk("t4_leftover", got.size(), 0);

        // Test 5: ncol=16 tile then ncol=3 tile, mid-tile changes ignored
        r0 = req_cnt;
        output_ready = 1'b0;
        vec_valid_num_col = 4'd0;
        push_row(8'h11, 1'b0);
        push_row(8'h22, 1'b1);
        repeat (3) step();
        vec_valid_num_col = 4'd5;
        push_row(8'h33, 1'b0);
        push_row(8'h44, 1'b1);
        vec_valid_num_col = 4'd3;
        output_ready = 1'b1;
        for (int i = 0; i < 200 && req_cnt < r0 + 2; i++) step();
        step();
        vec_valid_num_col = 4'd9;
        wait_words(10);
        repeat (3) step();
        chk("t5_req_cnt", req_cnt - r0, 2);
        q.delete(); q.push_back(8'h11); q.push_back(8'h22);
        check_tile("t5a", q, 16);
        q.delete(); q.push_back(8'h33); q.push_back(8'h44);
        check_tile("t5b", q, 3);
        chk("t5_leftover", got.size(), 0);

        // Test 6: asynchronous reset mid-transfer
        vec_valid_num_col = 4'd0;
        output_ready = 1'b0;
        push_row(8'hA0, 1'b0);
        push_row(8'hB0, 1'b0);
        push_row(8'hC0, 1'b1);
        repeat (3) step();
        chk("t6_in_xfer", output_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", {oa_fifo_req, output_valid, output_data, output_mask, switch_row}, 0);
        chk("t6_async_count", fifo_count, 0);
        chk("t6_async_ready", in_ready, 0);
        step();
        step();
        rst_n = 1'b1;
        r0 = req_cnt;
        repeat (10) step();
        chk("t6_post_count", fifo_count, 0);
        chk("t6_no_req", req_cnt - r0, 0);
        chk("t6_post_valid", output_valid, 0);
        chk("t6_no_words", got.size(), 0);
        output_ready = 1'b1;
        push_row(8'hD0, 1'b1);
        wait_words(4);
        repeat (3) step();
        chk("t6_new_req", req_cnt - r0, 1);
        q.delete(); q.push_back(8'hD0);
        check_tile("t6", q, 16);
        chk("t6_leftover", got.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
